// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg: shared types and constants for the PS/2 keyboard event controller
package ps2_kbd_pkg;
  typedef enum logic [1:0] {IDLE, EXT, REL, EXT_REL} kbd_state_t;
  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
  typedef struct packed {
    logic       released;
    logic       extended;
    logic [7:0] code;
  } kbd_event_t;
endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: synchronous FIFO with push/pop, full/empty flags and occupancy count
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 10,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  count_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign count_o = cnt_q;
  assign data_o = empty_o ? '0 : mem_q[rd_q];
  // a pop frees the slot the simultaneous push lands in, so a full FIFO still accepts
  always_comb begin
    do_pop = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: folds E0/F0 scan-code prefixes into key events and queues them for the CPU
module ps2_kbd_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_i,
  input  logic [7:0]               code_i,
  input  logic                     strobe_i,
  input  logic                     err_i,
  output logic [9:0]               event_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     err_o,
  input  logic                     clear_i
);
  kbd_state_t state_q, state_d;
  kbd_event_t ev;
  logic push, full, empty, drop;
  logic err_q, err_d, ovf_q, ovf_d;
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else state_q <= state_d;
  end
  // repeated prefixes are absorbed; only E0 after F0 upgrades to the combined state
  always_comb begin
    state_d = state_q;
    if (err_i) state_d = IDLE;
    else if (strobe_i)
      state_d = code_i == PS2_EXT_PREFIX ? (state_q == IDLE ? EXT : state_q == REL ? EXT_REL : state_q)
              : code_i == PS2_BRK_PREFIX ? (state_q == IDLE ? REL : state_q == EXT ? EXT_REL : state_q)
              : IDLE;
  end
  always_comb begin
    push = strobe_i & ~err_i & code_i != PS2_EXT_PREFIX & code_i != PS2_BRK_PREFIX;
    ev.released = state_q == REL || state_q == EXT_REL;
    ev.extended = state_q == EXT || state_q == EXT_REL;
    ev.code = code_i;
    drop = push & full & ~ready_i;
    err_d = err_i | (err_q & ~clear_i);
    ovf_d = drop | (ovf_q & ~clear_i);
  end
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      err_q <= err_d;
      ovf_q <= ovf_d;
    end
  end
  ps2_event_fifo #(.DEPTH(DEPTH), .W(10)) u_fifo (
    .clk(clk),
    .reset_i(reset_i),
    .push_i(push),
    .data_i(ev),
    .pop_i(ready_i),
    .data_o(event_o),
    .full_o(full),
    .empty_o(empty),
    .count_o(count_o)
  );
  assign valid_o = ~empty;
  assign err_o = err_q;
  assign overflow_o = ovf_q;
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl: directed stimulus checked every cycle against a queue-based model
module tb_ps2_kbd_ctrl;
  localparam int DEPTH = 8;
  logic clk = 0, reset_i = 1;
  logic [7:0] code_i = 0;
  logic strobe_i = 0, err_i = 0, ready_i = 0, clear_i = 0;
  logic [9:0] event_o;
  logic valid_o, overflow_o, err_o;
  logic [3:0] count_o;
  int total = 0, passed = 0;
  logic [9:0] mq[$];
  bit m_ext = 0, m_rel = 0, m_err = 0, m_ovf = 0;

  ps2_kbd_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_i(reset_i), .code_i(code_i), .strobe_i(strobe_i), .err_i(err_i),
    .event_o(event_o), .valid_o(valid_o), .ready_i(ready_i), .count_o(count_o),
    .overflow_o(overflow_o), .err_o(err_o), .clear_i(clear_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // model: prefixes are two independent flags; the queue holds {rel, ext, code}
  always @(posedge clk or posedge reset_i) begin
    bit pop;
    if (reset_i) begin
      mq.delete();
      m_ext = 0; m_rel = 0; m_err = 0; m_ovf = 0;
    end else begin
      pop = mq.size() > 0 && ready_i;
      if (clear_i) begin m_err = 0; m_ovf = 0; end
      if (pop) void'(mq.pop_front());
      if (err_i) begin
        m_err = 1; m_ext = 0; m_rel = 0;
      end else if (strobe_i) begin
        if (code_i == 8'hE0) m_ext = 1;
        else if (code_i == 8'hF0) m_rel = 1;
        else begin
          if (mq.size() < DEPTH) mq.push_back({m_rel, m_ext, code_i});
          else m_ovf = 1;
          m_ext = 0; m_rel = 0;
        end
      end
    end
    #1;
    chk("valid", valid_o, mq.size() > 0);
    chk("event", event_o, mq.size() > 0 ? mq[0] : 10'h0);
    chk("count", count_o, mq.size());
    chk("overflow", overflow_o, m_ovf);
    chk("err", err_o, m_err);
  end

  task automatic cyc(input logic s, input logic [7:0] c, input logic e, input logic r, input logic cl);
    @(negedge clk);
    strobe_i = s; code_i = c; err_i = e; ready_i = r; clear_i = cl;
  endtask

  task automatic idle();
    cyc(0, 8'h00, 0, 0, 0);
  endtask

  task automatic make(input logic [7:0] c);
    cyc(1, c, 0, 0, 0);
  endtask

  initial begin
    logic [7:0] exp6 [8];
    repeat (2) @(negedge clk);
    reset_i = 0;
    chk("reset valid", valid_o, 0);
    chk("reset count", count_o, 0);
    chk("reset event", event_o, 0);
    chk("reset flags", {overflow_o, err_o}, 0);
    make(8'h1C); idle();
    chk("make 1C event", event_o, 10'h01C);
    chk("make 1C count", count_o, 1);
    cyc(0, 0, 0, 1, 0); idle();
    chk("drain 1C", valid_o, 0);
    make(8'hE0); make(8'hF0); make(8'h75); idle();
    chk("ext break event", event_o, 10'h375);
    chk("ext break count", count_o, 1);
    cyc(0, 0, 0, 1, 0); idle();
    make(8'hF0); cyc(0, 0, 1, 0, 0); make(8'h1C); idle();
    chk("err sticky", err_o, 1);
    chk("err discards break", event_o, 10'h01C);
    cyc(0, 0, 0, 0, 1); idle();
    chk("err cleared", err_o, 0);
    cyc(0, 0, 0, 1, 0);
    make(8'hF0); make(8'hE0); make(8'hE0); make(8'hF0); make(8'h6C); make(8'hE1);
    make(8'hFA); cyc(1, 8'h33, 1, 0, 0); idle();
    chk("absorbed prefixes", event_o, 10'h36C);
    chk("plain codes count", count_o, 3);
    repeat (3) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1); idle();
    for (int i = 1; i <= 9; i++) make(8'(i));
    idle();
    chk("fill count", count_o, 8);
    chk("fill overflow", overflow_o, 1);
    for (int i = 1; i <= 8; i++) begin
      chk("drain order", event_o, 10'(i));
      cyc(0, 0, 0, 1, 0); idle();
    end
    chk("drained", valid_o, 0);
    cyc(0, 0, 0, 0, 1); idle();
    chk("ovf cleared", overflow_o, 0);
    for (int i = 0; i < 8; i++) make(8'h11 + 8'(i));
    cyc(1, 8'h2A, 0, 1, 0); idle();
    chk("full+pop no ovf", overflow_o, 0);
    chk("full+pop count", count_o, 8);
    for (int i = 0; i < 7; i++) exp6[i] = 8'h12 + 8'(i);
    exp6[7] = 8'h2A;
    for (int i = 0; i < 8; i++) begin
      chk("full+pop order", event_o, {2'b00, exp6[i]});
      cyc(0, 0, 0, 1, 0); idle();
    end
    make(8'h21); make(8'h22); make(8'h23); make(8'hE0); idle();
    @(posedge clk); #2;
    reset_i = 1; #1;
    chk("async reset valid", valid_o, 0);
    chk("async reset count", count_o, 0);
    @(negedge clk);
    reset_i = 0;
    make(8'h6B); idle();
    chk("post reset event", event_o, 10'h06B);
    repeat (2) idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_ctrl.md
# ps2_kbd_ctrl

Keyboard event controller between the `ps2kbd` receiver and the `xgsoc` CPU-facing PS/2 port. It consumes raw scan-code strobes, folds `E0` (extended) and `F0` (break) prefixes into single key events, and buffers them in a FIFO with a valid/ready pop handshake. Sticky overflow and receive-error flags are exposed for the CPU to poll and clear.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `clk`  in  1  system clock (12 MHz on iCEBreaker).
- `reset_i`  in  1  reset, asynchronous, active-high.
- `code_i`  in  8  scan code from `ps2kbd`; valid only when `strobe_i`=1.
- `strobe_i`  in  1  one-cycle pulse: `code_i` holds a new byte.
- `err_i`  in  1  one-cycle pulse: frame/parity error from `ps2kbd`.
- `event_o`  out  10  FIFO head `{released, extended, code[7:0]}`; 0 when `valid_o`=0.
- `valid_o`  out  1  FIFO non-empty.
- `ready_i`  in  1  consumer pop; pop occurs on an edge where `valid_o & ready_i`.
- `count_o`  out  $clog2(DEPTH)+1  entries currently held.
- `overflow_o`  out  1  sticky: an event was dropped because the FIFO was full.
- `err_o`  out  1  sticky: `err_i` was seen.
- `clear_i`  in  1  one-cycle pulse clearing `overflow_o` and `err_o`.

## Operation
- Prefix FSM states: IDLE, EXT (seen `E0`), REL (seen `F0`), EXT_REL (seen `E0 F0`).
- Strobe transitions: IDLE+`E0`→EXT; IDLE+`F0`→REL; EXT+`F0`→EXT_REL; any other code in any state → push `{rel, ext, code}` with rel/ext taken from the current state, then →IDLE.
- Redundant prefixes (`E0` in EXT/EXT_REL, `F0` in REL/EXT_REL, `E0` in REL) are absorbed: state unchanged except REL+`E0`→EXT_REL.
- `E1` and device replies (`AA`, `FA`, `FE`, `EE`) are not special: pushed as ordinary codes.
- `err_i`=1: set `err_o`, FSM→IDLE, partial prefixes discarded; a `strobe_i` in the same cycle is dropped (no push).
- Push when full and no pop in the same cycle: event dropped, `overflow_o` set, FSM→IDLE as normal.
- Push and pop in the same cycle: both occur; a push into a full FIFO with simultaneous pop is accepted, no overflow.
- Pop when empty: ignored (cannot happen since `valid_o`=0).
- `clear_i` clears both sticky flags; if a set condition occurs in the same cycle, set wins.
- `clear_i` does not flush the FIFO or reset the FSM.
- Pointers wrap modulo DEPTH; `count_o` is in 0..DEPTH.

## Timing
- Reset values: `event_o`=0, `valid_o`=0, `count_o`=0, `overflow_o`=0, `err_o`=0; FSM IDLE; pointers 0. `reset_i` takes effect immediately and asynchronously, mid-sequence included; pending prefixes are lost.
- Push latency: strobe of a terminal code at edge N into an empty FIFO → `valid_o`=1 and `event_o` valid after edge N, i.e. in cycle N+1.
- Pop: `valid_o & ready_i` at edge N → next head (or `valid_o`=0) visible in cycle N+1.
- `count_o`, `overflow_o`, `err_o` are registered and update one cycle after the causing edge.
- Back-to-back strobes on consecutive cycles are supported (no internal bubble).

## Structure
- Package `ps2_kbd_pkg`: state enum `kbd_state_t`; constants `PS2_EXT_PREFIX`=8'hE0, `PS2_BRK_PREFIX`=8'hF0; packed struct `kbd_event_t {released, extended, code}`.
- One sub-module: `ps2_event_fifo` (parametric sync FIFO: push/pop, full/empty, count, async reset). The FSM and flag logic live in `ps2_kbd_ctrl`.

## Test plan
- Make code `1C` (strobe 1C) → one event `{0,0,1C}` in cycle N+1; `count_o`=1.
- Sequence `E0 F0 75` with `ready_i`=0 → single event `{1,1,75}`; no events for the prefixes.
- `F0`, then `err_i` pulse, then `1C` → `err_o`=1, event `{0,0,1C}` (break flag discarded); `clear_i` → `err_o`=0.
- DEPTH+1 make codes `01..09` (DEPTH=8), `ready_i`=0 → `count_o`=8, `overflow_o`=1, drain yields `01..08` in order.
- FIFO full, strobe `2A` with `ready_i`=1 in the same cycle → `overflow_o` stays 0, `count_o` stays 8, `2A` is the last event drained.
- Assert `reset_i` after `E0` with 3 events queued → `valid_o`=0 and `count_o`=0 immediately; post-reset `6B` → `{0,0,6B}`.
